pc_fetch_unit: RTL and testbench

//   Program-counter register and instruction-fetch sequencer for the RISC-V single-cycle core.

---
 rtl/pc_fetch_unit_pkg.sv | 15 +
 rtl/pc_fetch_unit_if.sv | 12 +
 rtl/pc_fetch_unit_instret_counter.sv | 19 +
 rtl/pc_fetch_unit.sv | 88 ++++++++
 tb/tb_pc_fetch_unit.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the PC fetch unit: FSM encoding, address width, instruction size.
package fetch_pkg;

    localparam int ADDR_W = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_REQ   = 2'd1,
        ST_STALL = 2'd2,
        ST_TRAP  = 2'd3
    } state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory request channel (valid/ready with fetch address).
interface pc_fetch_unit_if;
    import fetch_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_addr;

    modport master (output imem_req_valid, output imem_addr, input imem_req_ready);
    modport slave  (input imem_req_valid, input imem_addr, output imem_req_ready);

endinterface

// File: rtl/pc_fetch_unit_instret_counter.sv
// Enable-increment counter of accepted fetches; wraps to zero after all-ones.
module instret_counter #(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer. Define MISALIGN_TRAP_EN to trap on misaligned next_pc
// instead of silently clearing its low two bits.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          CNT_W    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic [31:0]          next_pc,
    pc_fetch_unit_if.master      imem,
    output logic [31:0]          pc,
    output logic [31:0]          pc_plus4,
    output logic                 fetch_done,
    output logic [CNT_W-1:0]     instret,
    output logic                 trap
);

    state_e state_q, state_d;
    logic   req_valid;
    logic   handshake;
    logic   misaligned;

    assign handshake = req_valid && imem.imem_req_ready;

`ifdef MISALIGN_TRAP_EN
    assign misaligned = (next_pc[1:0] != 2'b00);
    assign trap       = (state_q == ST_TRAP);
`else
    assign misaligned = 1'b0;
    assign trap       = 1'b0;
`endif

    // valid is decoded from the state register so reset clears it immediately
    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        case (state_q)
            ST_BOOT:  state_d = stall ? ST_STALL : ST_REQ;
            ST_REQ: begin
                req_valid = 1'b1;
                if (handshake) begin
                    if (misaligned)  state_d = ST_TRAP;
                    else if (stall)  state_d = ST_STALL;
                    else             state_d = ST_REQ;
                end
            end
            ST_STALL: state_d = stall ? ST_STALL : ST_REQ;
            ST_TRAP:  state_d = ST_TRAP;
            default:  state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Low bits are masked on load; with the trap enabled a misaligned target never loads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            fetch_done <= 1'b0;
        end else begin
            fetch_done <= handshake;
            if (handshake && !misaligned) begin
                pc <= next_pc & 32'hFFFF_FFFC;
            end
        end
    end

    assign pc_plus4            = pc + 32'(INSTR_BYTES);
    assign imem.imem_req_valid = req_valid;
    assign imem.imem_addr      = pc;

    instret_counter #(.CNT_W(CNT_W)) u_instret (
        .clk   (clk),
        .rst   (rst),
        .en    (handshake),
        .count (instret)
    );

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with a scoreboard of expected PCs per accepted fetch.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        use_p4;
    logic [31:0] np;
    logic [31:0] next_pc;
    logic [31:0] pc, pc_plus4;
    logic        fetch_done, trap;
    logic [63:0] instret;

    logic        stall2;
    logic [31:0] next_pc2, pc2, pc_plus4_2;
    logic        fetch_done2, trap2;
    logic [1:0]  instret2;

    int errors = 0;
    int checks = 0;
    logic [31:0] sb[$];

    pc_fetch_unit_if bus ();
    pc_fetch_unit_if bus2 ();

    always #5 clk = ~clk;

    assign next_pc            = use_p4 ? pc_plus4 : np;
    assign next_pc2           = pc_plus4_2;
    assign bus2.imem_req_ready = 1'b1;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .next_pc    (next_pc),
        .imem       (bus.master),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .fetch_done (fetch_done),
        .instret    (instret),
        .trap       (trap)
    );

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(2)) dut_wrap (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall2),
        .next_pc    (next_pc2),
        .imem       (bus2.master),
        .pc         (pc2),
        .pc_plus4   (pc_plus4_2),
        .fetch_done (fetch_done2),
        .instret    (instret2),
        .trap       (trap2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        logic [31:0] e;
        @(posedge clk);
        #1;
        if (fetch_done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_pc", {32'd0, pc}, {32'd0, e});
            end
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; stall2 = 1'b0; use_p4 = 1'b0; np = '0;
        bus.imem_req_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_valid", {63'd0, bus.imem_req_valid}, 64'd0);
        chk("rst_pc", {32'd0, pc}, 64'd0);
        chk("rst_instret", instret, 64'd0);
        chk("rst_trap", {63'd0, trap}, 64'd0);

        // 1: boot then back-to-back sequential fetches
        rst = 1'b0; bus.imem_req_ready = 1'b1; use_p4 = 1'b1;
        #1;
        chk("boot_valid", {63'd0, bus.imem_req_valid}, 64'd0);
        cyc();
        chk("req_valid", {63'd0, bus.imem_req_valid}, 64'd1);
        chk("pc0", {32'd0, pc}, 64'h0);
        sb.push_back(32'h4);  cyc(); chk("pc4", {32'd0, pc}, 64'h4);
        sb.push_back(32'h8);  cyc(); chk("pc8", {32'd0, pc}, 64'h8);
        sb.push_back(32'hC);  cyc(); chk("pcC", {32'd0, pc}, 64'hC);
        sb.push_back(32'h10); cyc();
        chk("instret4", instret, 64'd4);
        chk("wrap_cnt0", {62'd0, instret2}, 64'd0);

        // 2: ready held low with request pending at 0x10
        bus.imem_req_ready = 1'b0; use_p4 = 1'b0; np = 32'h20;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("hold_addr", {32'd0, bus.imem_addr}, 64'h10);
            chk("hold_valid", {63'd0, bus.imem_req_valid}, 64'd1);
            chk("hold_nodone", {63'd0, fetch_done}, 64'd0);
            if (i == 0) chk("wrap_cnt1", {62'd0, instret2}, 64'd1);
        end
        bus.imem_req_ready = 1'b1; sb.push_back(32'h20);
        cyc();
        chk("done_after_hold", {63'd0, fetch_done}, 64'd1);
        chk("instret5", instret, 64'd5);

        // 3: stall raised while a request is in flight at 0x20
        bus.imem_req_ready = 1'b0; stall = 1'b1; np = 32'h24;
        cyc();
        chk("inflight_valid", {63'd0, bus.imem_req_valid}, 64'd1);
        chk("inflight_pc", {32'd0, pc}, 64'h20);
        bus.imem_req_ready = 1'b1; sb.push_back(32'h24);
        cyc();
        chk("stall_valid", {63'd0, bus.imem_req_valid}, 64'd0);
        cyc();
        chk("stall_hold_pc", {32'd0, pc}, 64'h24);
        chk("stall_valid2", {63'd0, bus.imem_req_valid}, 64'd0);
        chk("stall_nodone", {63'd0, fetch_done}, 64'd0);
        stall = 1'b0;
        cyc();
        chk("resume_valid", {63'd0, bus.imem_req_valid}, 64'd1);
        chk("instret6", instret, 64'd6);

        // 4: top-of-address-space wrap
        np = 32'hFFFF_FFFC; sb.push_back(32'hFFFF_FFFC);
        cyc();
        chk("p4_wrap", {32'd0, pc_plus4}, 64'h0);
        use_p4 = 1'b1; sb.push_back(32'h0);
        cyc();
        chk("pc_wrapped", {32'd0, pc}, 64'h0);
        bus.imem_req_ready = 1'b0; use_p4 = 1'b0;
        cyc();

        // 5: misaligned target
        np = 32'h0000_0102; bus.imem_req_ready = 1'b1;
`ifdef MISALIGN_TRAP_EN
        sb.push_back(32'h0);
        cyc();
        chk("trap_set", {63'd0, trap}, 64'd1);
        chk("trap_instret", instret, 64'd9);
        cyc(); cyc();
        chk("trap_valid", {63'd0, bus.imem_req_valid}, 64'd0);
        chk("trap_pc", {32'd0, pc}, 64'h0);
        chk("trap_sticky", {63'd0, trap}, 64'd1);
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
        bus.imem_req_ready = 1'b0; np = 32'h200;
        cyc();
        bus.imem_req_ready = 1'b1; sb.push_back(32'h200);
        cyc();
        bus.imem_req_ready = 1'b0;
`else
        sb.push_back(32'h100);
        cyc();
        chk("mask_pc", {32'd0, pc}, 64'h100);
        chk("no_trap", {63'd0, trap}, 64'd0);
        chk("instret9", instret, 64'd9);
        bus.imem_req_ready = 1'b0;
`endif

        // 6: async reset in the middle of a pending request
        chk("pre_rst_valid", {63'd0, bus.imem_req_valid}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_valid", {63'd0, bus.imem_req_valid}, 64'd0);
        chk("async_pc", {32'd0, pc}, 64'h0);
        chk("async_instret", instret, 64'd0);
        chk("async_done", {63'd0, fetch_done}, 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
